// File: rtl/pos_mask_splitter.sv
// pos_mask_splitter: splits a merged bit mask into one index per beat, LSB first.
// Define POS_SPLIT_PIPE_EN to let the last beat and the next mask accept share a cycle.
module pos_mask_splitter #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_mask_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             out_last_o,
  output logic             zero_o,
  output logic             busy_o
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic zero_q, zero_d;
  logic [IDX_W-1:0] low_idx;
  logic one_hot, accept, fire;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mask_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      zero_q  <= zero_d;
    end
  end
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (mask_q[i]) low_idx = IDX_W'(i);
    one_hot = (mask_q != '0) && ((mask_q & (mask_q - WIDTH'(1))) == '0);
  end
  always_comb begin
    out_valid_o = state_q == SCAN;
    busy_o      = state_q == SCAN;
    out_idx_o   = out_valid_o ? low_idx : '0;
    out_last_o  = out_valid_o & one_hot;
    zero_o      = zero_q;
`ifdef POS_SPLIT_PIPE_EN
    in_ready_o  = (state_q == IDLE) | (out_last_o & out_ready_i);
`else
    in_ready_o  = state_q == IDLE;
`endif
  end
  assign accept = in_valid_i & in_ready_o;
  assign fire   = out_valid_o & out_ready_i;
  // A finishing SCAN with a same-edge accept behaves exactly like an IDLE accept.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    zero_d  = 1'b0;
    if (state_q == SCAN && fire) begin
      mask_d = mask_q & (mask_q - WIDTH'(1));
      if (one_hot) state_d = IDLE;
    end
    if (accept) begin
      state_d = (in_mask_i != '0) ? SCAN : IDLE;
      mask_d  = (in_mask_i != '0) ? in_mask_i : mask_d;
      zero_d  = in_mask_i == '0;
    end
  end
endmodule

// File: tb/tb_pos_mask_splitter.sv
// tb_pos_mask_splitter: directed vectors with hand-computed expectations.
module tb_pos_mask_splitter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] in_mask = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [3:0] out_idx;
  logic out_last, zero, busy;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  pos_mask_splitter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_mask_i(in_mask),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_idx_o(out_idx), .out_last_o(out_last),
    .zero_o(zero), .busy_o(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input string tag, input logic [3:0] idx, input logic last);
    chk({tag, " valid"}, 32'(out_valid), 1);
    chk({tag, " idx"}, 32'(out_idx), 32'(idx));
    chk({tag, " last"}, 32'(out_last), 32'(last));
    chk({tag, " busy"}, 32'(busy), 1);
  endtask
  task automatic idle(input string tag);
    chk({tag, " valid"}, 32'(out_valid), 0);
    chk({tag, " idx"}, 32'(out_idx), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " in_ready"}, 32'(in_ready), 1);
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  initial begin
    tick();
    idle("reset");
    chk("reset last", 32'(out_last), 0);
    chk("reset zero", 32'(zero), 0);
    rst_n = 1'b1;
    // 1: 0x0005
    tick();
    in_valid = 1'b1; in_mask = 16'h0005; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    beat("t1 b0", 4'd0, 1'b0);
    chk("t1 in_ready scan", 32'(in_ready), 0);
    tick();
    beat("t1 b1", 4'd2, 1'b1);
    tick();
    idle("t1 done");
    // 2: zero mask
    in_valid = 1'b1; in_mask = 16'h0000;
    #1 chk("t2 zero before", 32'(zero), 0);
    tick();
    in_valid = 1'b0;
    idle("t2 pulse");
    chk("t2 zero pulse", 32'(zero), 1);
    tick();
    idle("t2 after");
    chk("t2 zero clear", 32'(zero), 0);
    // 3: 0x8001 with stalls; mask offered during SCAN must be ignored
    in_valid = 1'b1; in_mask = 16'h8001;
    tick();
    in_mask = 16'h0F0F; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat($sformatf("t3 stall%0d", i), 4'd0, 1'b0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1 beat("t3 release", 4'd0, 1'b0);
    tick();
    beat("t3 b1", 4'd15, 1'b1);
    tick();
    idle("t3 done");
    // 4: 0xFFFF
    in_valid = 1'b1; in_mask = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      beat($sformatf("t4 b%0d", i), 4'(i), i == 15);
      tick();
    end
    idle("t4 done");
    // 5: reset mid-scan
    in_valid = 1'b1; in_mask = 16'h00F0;
    tick();
    in_valid = 1'b0;
    beat("t5 b0", 4'd4, 1'b0);
    tick();
    beat("t5 b1", 4'd5, 1'b0);
    tick();
    rst_n = 1'b0;
    #1 idle("t5 in reset");
    chk("t5 last in reset", 32'(out_last), 0);
    tick();
    rst_n = 1'b1;
    tick();
    idle("t5 after release");
    tick();
    idle("t5 stays idle");
    // 6: back-to-back 0x0003, 0x0100
    in_valid = 1'b1; in_mask = 16'h0003;
    tick();
    in_mask = 16'h0100;
    beat("t6 b0", 4'd0, 1'b0);
    chk("t6 in_ready b0", 32'(in_ready), 0);
    tick();
    beat("t6 b1", 4'd1, 1'b1);
`ifdef POS_SPLIT_PIPE_EN
    chk("t6 in_ready last", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    beat("t6 b2", 4'd8, 1'b1);
`else
    chk("t6 in_ready last", 32'(in_ready), 0);
    tick();
    idle("t6 bubble");
    tick();
    in_valid = 1'b0;
    beat("t6 b2", 4'd8, 1'b1);
`endif
    tick();
    idle("t6 done");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
